// File: rtl/ray_aabb_slab_test_if.sv
// Request/result bundle for the ray/AABB slab unit.
// The producer side drives the ray/box request and the result ready.
interface ray_aabb_slab_test_if #(
    parameter int TAG_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [TAG_W-1:0]        in_tag;
    logic signed [27:0]      origin_x, origin_y, origin_z;
    logic signed [35:0]      inv_dir_x, inv_dir_y, inv_dir_z;
    logic                    dz_x, dz_y, dz_z;
    logic signed [27:0]      box_min_x, box_min_y, box_min_z;
    logic signed [27:0]      box_max_x, box_max_y, box_max_z;
    logic                    out_valid;
    logic                    out_ready;
    logic [TAG_W-1:0]        out_tag;
    logic                    hit;
    logic signed [35:0]      t_near, t_far;

    modport master (
        output in_valid, in_tag,
        output origin_x, origin_y, origin_z,
        output inv_dir_x, inv_dir_y, inv_dir_z,
        output dz_x, dz_y, dz_z,
        output box_min_x, box_min_y, box_min_z,
        output box_max_x, box_max_y, box_max_z,
        output out_ready,
        input  in_ready, out_valid, out_tag,
        input  hit, t_near, t_far
    );

    modport slave (
        input  in_valid, in_tag,
        input  origin_x, origin_y, origin_z,
        input  inv_dir_x, inv_dir_y, inv_dir_z,
        input  dz_x, dz_y, dz_z,
        input  box_min_x, box_min_y, box_min_z,
        input  box_max_x, box_max_y, box_max_z,
        input  out_ready,
        output in_ready, out_valid, out_tag,
        output hit, t_near, t_far
    );
endinterface

// File: rtl/ray_aabb_slab_test.sv
// Five-stage ray/AABB slab intersection: offsets, products,
// per-axis slab interval, interval merge, hit decision.
module ray_aabb_slab_test #(
    parameter int TAG_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ray_aabb_slab_test_if.slave   io
);
    localparam logic signed [35:0] MAX36 = 36'sh7_FFFF_FFFF;
    localparam logic signed [35:0] MIN36 = 36'sh8_0000_0000;

    logic signed [27:0] org [3];
    logic signed [27:0] bmin [3];
    logic signed [27:0] bmax [3];
    logic signed [35:0] inv [3];
    logic [2:0]         dz;

    assign org  = '{io.origin_x, io.origin_y, io.origin_z};
    assign bmin = '{io.box_min_x, io.box_min_y, io.box_min_z};
    assign bmax = '{io.box_max_x, io.box_max_y, io.box_max_z};
    assign inv  = '{io.inv_dir_x, io.inv_dir_y, io.inv_dir_z};
    assign dz   = {io.dz_z, io.dz_y, io.dz_x};

    logic en;

    logic               v1_q, v2_q, v3_q, v4_q, out_valid_q;
    logic [TAG_W-1:0]   tag1_q, tag2_q, tag3_q, tag4_q, out_tag_q;
    logic signed [28:0] dlo1_q [3];
    logic signed [28:0] dhi1_q [3];
    logic signed [35:0] inv1_q [3];
    logic [2:0]         dz1_q, dz2_q, in2_q;
    logic signed [64:0] plo2_q [3];
    logic signed [64:0] phi2_q [3];
    logic signed [35:0] near3_q [3];
    logic signed [35:0] far3_q [3];
    logic               miss3_q, miss4_q, hit_q;
    logic signed [35:0] tn4_q, tf4_q, tn_q, tf_q;

    logic signed [35:0] tlo_d [3];
    logic signed [35:0] thi_d [3];
    logic signed [35:0] near_d [3];
    logic signed [35:0] far_d [3];
    logic               miss_d, hit_d;
    logic signed [35:0] tn_d, tf_d;

    assign en          = !out_valid_q || io.out_ready;
    assign io.in_ready = en;

    // Drop the 16 extra fraction bits of the Q.32 product, clamp to 36 bits.
    function automatic logic signed [35:0] sat(input logic signed [64:0] p);
        logic signed [48:0] s;
        s = 49'(p >>> 16);
        if (s > 49'sd34359738367)
            return MAX36;
        else if (s < -49'sd34359738368)
            return MIN36;
        else
            return s[35:0];
    endfunction

    always_comb begin
        miss_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tlo_d[i]  = sat(plo2_q[i]);
            thi_d[i]  = sat(phi2_q[i]);
            near_d[i] = (tlo_d[i] < thi_d[i]) ? tlo_d[i] : thi_d[i];
            far_d[i]  = (tlo_d[i] < thi_d[i]) ? thi_d[i] : tlo_d[i];
            if (dz2_q[i]) begin
                near_d[i] = MIN36;
                far_d[i]  = MAX36;
                miss_d    = miss_d | !in2_q[i];
            end
        end
    end

    always_comb begin
        tn_d = near3_q[0];
        tf_d = far3_q[0];
        for (int i = 1; i < 3; i++) begin
            if (near3_q[i] > tn_d) tn_d = near3_q[i];
            if (far3_q[i] < tf_d)  tf_d = far3_q[i];
        end
    end

    assign hit_d = !miss4_q && (tn4_q <= tf4_q) && (tf4_q >= 36'sd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            v4_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            hit_q       <= 1'b0;
            tn_q        <= '0;
            tf_q        <= '0;
        end else if (en) begin
            v1_q   <= io.in_valid;
            tag1_q <= io.in_tag;
            dz1_q  <= dz;
            for (int i = 0; i < 3; i++) begin
                dlo1_q[i]  <= {bmin[i][27], bmin[i]} - {org[i][27], org[i]};
                dhi1_q[i]  <= {bmax[i][27], bmax[i]} - {org[i][27], org[i]};
                inv1_q[i]  <= inv[i];
                plo2_q[i]  <= 65'(dlo1_q[i]) * 65'(inv1_q[i]);
                phi2_q[i]  <= 65'(dhi1_q[i]) * 65'(inv1_q[i]);
                in2_q[i]   <= (dlo1_q[i] <= 29'sd0) && (dhi1_q[i] >= 29'sd0);
                near3_q[i] <= near_d[i];
                far3_q[i]  <= far_d[i];
            end
            v2_q        <= v1_q;
            tag2_q      <= tag1_q;
            dz2_q       <= dz1_q;
            v3_q        <= v2_q;
            tag3_q      <= tag2_q;
            miss3_q     <= miss_d;
            v4_q        <= v3_q;
            tag4_q      <= tag3_q;
            tn4_q       <= tn_d;
            tf4_q       <= tf_d;
            miss4_q     <= miss3_q;
            out_valid_q <= v4_q;
            out_tag_q   <= tag4_q;
            hit_q       <= hit_d;
            tn_q        <= tn4_q;
            tf_q        <= tf4_q;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_tag   = out_tag_q;
    assign io.hit       = hit_q;
    assign io.t_near    = tn_q;
    assign io.t_far     = tf_q;
endmodule

// File: tb/tb_ray_aabb_slab_test.sv
// Bench for ray_aabb_slab_test: directed slab cases, stall and reset
// sequences, then random traffic against a plain-arithmetic model.
module tb_ray_aabb_slab_test;
    localparam logic signed [35:0] MAX36 = 36'sh7_FFFF_FFFF;
    localparam logic signed [35:0] MIN36 = 36'sh8_0000_0000;
    localparam logic signed [35:0] INV1  = 36'sh0_0001_0000;
    localparam logic signed [35:0] INVN1 = 36'shF_FFFF_0000;
    localparam int ONE = 65536;

    typedef struct {
        logic signed [27:0] o [3];
        logic signed [27:0] lo [3];
        logic signed [27:0] hi [3];
        logic signed [35:0] inv [3];
        logic               dz [3];
    } req_t;

    typedef struct {
        logic [15:0]        tag;
        logic               hit;
        logic signed [35:0] tn;
        logic signed [35:0] tf;
        int                 acc_cyc;
        int                 acc_stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ray_aabb_slab_test_if #(.TAG_W(16)) io ();
    ray_aabb_slab_test #(.TAG_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int   checks = 0;
    int   errs = 0;
    int   cyc_n = 0;
    int   stall_n = 0;
    int   nret = 0;
    exp_t q[$];
    bit   seen = 0;
    bit   last_acc = 0;
    req_t cur;
    logic [15:0] cur_tag;
    bit   ov_hit_en = 0;
    bit   ov_t_en = 0;
    logic ov_hit;
    logic signed [35:0] ov_tn, ov_tf;

    task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic signed [35:0] clamp(logic signed [127:0] v);
        if (v > 128'sd34359738367) return MAX36;
        if (v < -128'sd34359738368) return MIN36;
        return v[35:0];
    endfunction

    // Slab method: each axis bounds t to an interval, the ray hits when
    // the intersection of the three intervals is non-empty and not behind.
    function automatic exp_t model(req_t r, logic [15:0] tag);
        exp_t e;
        logic signed [35:0] tn, tf, a, b;
        bit miss;
        tn = MIN36;
        tf = MAX36;
        miss = 0;
        for (int i = 0; i < 3; i++) begin
            if (r.dz[i]) begin
                if (r.o[i] < r.lo[i] || r.o[i] > r.hi[i]) miss = 1;
            end else begin
                a = clamp(((128'(r.lo[i]) - 128'(r.o[i])) * 128'(r.inv[i])) >>> 16);
                b = clamp(((128'(r.hi[i]) - 128'(r.o[i])) * 128'(r.inv[i])) >>> 16);
                if (((a < b) ? a : b) > tn) tn = (a < b) ? a : b;
                if (((a < b) ? b : a) < tf) tf = (a < b) ? b : a;
            end
        end
        e.tag = tag;
        e.hit = !miss && (tn <= tf) && (tf >= 36'sd0);
        e.tn = tn;
        e.tf = tf;
        e.acc_cyc = 0;
        e.acc_stall = 0;
        return e;
    endfunction

    function automatic req_t mk(int o, int lo, int hi, logic signed [35:0] inv);
        req_t r;
        for (int i = 0; i < 3; i++) begin
            r.o[i] = 28'(o);
            r.lo[i] = 28'(lo);
            r.hi[i] = 28'(hi);
            r.inv[i] = inv;
            r.dz[i] = 1'b0;
        end
        return r;
    endfunction

    function automatic req_t rnd();
        req_t r;
        logic signed [27:0] x, y;
        for (int i = 0; i < 3; i++) begin
            r.o[i] = 28'($signed(22'($urandom())));
            x = 28'($signed(22'($urandom())));
            y = 28'($signed(22'($urandom())));
            r.lo[i] = (x < y) ? x : y;
            r.hi[i] = (x < y) ? y : x;
            if ($urandom_range(0, 1) == 1)
                r.inv[i] = 36'({$urandom(), $urandom()});
            else
                r.inv[i] = 36'($signed(20'($urandom())));
            r.dz[i] = ($urandom_range(0, 7) == 0);
        end
        return r;
    endfunction

    task automatic drive();
        io.in_tag = cur_tag;
        io.origin_x = cur.o[0];
        io.origin_y = cur.o[1];
        io.origin_z = cur.o[2];
        io.box_min_x = cur.lo[0];
        io.box_min_y = cur.lo[1];
        io.box_min_z = cur.lo[2];
        io.box_max_x = cur.hi[0];
        io.box_max_y = cur.hi[1];
        io.box_max_z = cur.hi[2];
        io.inv_dir_x = cur.inv[0];
        io.inv_dir_y = cur.inv[1];
        io.inv_dir_z = cur.inv[2];
        io.dz_x = cur.dz[0];
        io.dz_y = cur.dz[1];
        io.dz_z = cur.dz[2];
    endtask

    // One clock: sample handshakes mid-cycle, score, then advance.
    task automatic cyc();
        bit acc, ret, stl;
        exp_t e;
        drive();
        #1;
        acc = io.in_valid && io.in_ready && !rst;
        ret = io.out_valid && io.out_ready && !rst;
        stl = io.out_valid && !io.out_ready;
        last_acc = acc;
        if (!rst) begin
            if (q.size() == 0) begin
                check("idle_ov", io.out_valid, 1'b0);
            end else if (io.out_valid) begin
                if (!seen) begin
                    check("latency", cyc_n - q[0].acc_cyc,
                          5 + stall_n - q[0].acc_stall);
                    seen = 1;
                end
                check("tag", io.out_tag, q[0].tag);
                check("hit", io.hit, q[0].hit);
                check("t_near", io.t_near, q[0].tn);
                check("t_far", io.t_far, q[0].tf);
                if (ret) begin
                    void'(q.pop_front());
                    seen = 0;
                    nret++;
                end
            end
        end
        if (acc) begin
            e = model(cur, cur_tag);
            if (ov_hit_en) e.hit = ov_hit;
            if (ov_t_en) begin
                e.tn = ov_tn;
                e.tf = ov_tf;
            end
            e.acc_cyc = cyc_n;
            e.acc_stall = stall_n;
            q.push_back(e);
        end
        if (stl && !rst) stall_n++;
        @(posedge clk);
        cyc_n++;
        if (rst) begin
            q.delete();
            seen = 0;
        end
        #1;
    endtask

    task automatic send(req_t r, logic [15:0] tag);
        cur = r;
        cur_tag = tag;
        io.in_valid = 1'b1;
        io.out_ready = 1'b1;
        cyc();
        check("accepted", last_acc, 1'b1);
        io.in_valid = 1'b0;
        ov_hit_en = 0;
        ov_t_en = 0;
        repeat (8) cyc();
        check("drain", q.size(), 0);
    endtask

    initial begin
        req_t r;
        int t, n0;
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        cur = mk(0, 0, 0, INV1);
        cur_tag = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", io.out_valid, 1'b0);
        check("rst_hit", io.hit, 1'b0);
        check("rst_t_near", io.t_near, 36'sd0);
        check("rst_t_far", io.t_far, 36'sd0);
        check("rst_out_tag", io.out_tag, 16'h0);
        check("rst_in_ready", io.in_ready, 1'b1);
        rst = 1'b0;

        // Unit box [1,2]^3 seen from the origin along (1,1,1).
        ov_hit_en = 1; ov_hit = 1'b1;
        ov_t_en = 1; ov_tn = 36'sh1_0000; ov_tf = 36'sh2_0000;
        send(mk(0, ONE, 2 * ONE, INV1), 16'h0001);

        r = mk(0, ONE, 2 * ONE, INV1);
        r.lo[0] = 28'(-2 * ONE);
        r.hi[0] = 28'(-ONE);
        r.inv[0] = INVN1;
        ov_hit_en = 1; ov_hit = 1'b1;
        ov_t_en = 1; ov_tn = 36'sh1_0000; ov_tf = 36'sh2_0000;
        send(r, 16'h0002);

        r = mk(0, ONE, 2 * ONE, INV1);
        r.o[0] = 28'(5 * ONE);
        r.dz[0] = 1'b1;
        r.inv[0] = INVN1;
        ov_hit_en = 1; ov_hit = 1'b0;
        send(r, 16'h0003);

        r.o[0] = 28'(3 * ONE / 2);
        ov_hit_en = 1; ov_hit = 1'b1;
        ov_t_en = 1; ov_tn = 36'sh1_0000; ov_tf = 36'sh2_0000;
        send(r, 16'h0004);

        ov_hit_en = 1; ov_hit = 1'b0;
        ov_t_en = 1; ov_tn = 36'shF_FFFE_0000; ov_tf = 36'shF_FFFF_0000;
        send(mk(0, -2 * ONE, -ONE, INV1), 16'h0005);

        ov_hit_en = 1; ov_hit = 1'b1;
        ov_t_en = 1; ov_tn = MAX36; ov_tf = MAX36;
        send(mk(0, 100 * ONE, 100 * ONE, MAX36), 16'h0006);

        // Back-to-back tags 0..7 with the consumer stalling mid-stream.
        n0 = nret;
        t = 0;
        for (int k = 0; k < 40 && t < 8; k++) begin
            cur = rnd();
            cur_tag = 16'(t);
            io.in_valid = 1'b1;
            io.out_ready = !(k >= 6 && k <= 8);
            cyc();
            if (last_acc) t++;
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        repeat (10) cyc();
        check("b2b_sent", t, 8);
        check("b2b_retired", nret - n0, 8);
        check("b2b_drain", q.size(), 0);

        // Reset with three requests in flight.
        for (int i = 0; i < 3; i++) begin
            cur = rnd();
            cur_tag = 16'(16'h100 + i);
            io.in_valid = 1'b1;
            cyc();
        end
        io.in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        check("flush_out_valid", io.out_valid, 1'b0);
        rst = 1'b0;
        repeat (12) cyc();
        check("flush_in_ready", io.in_ready, 1'b1);

        for (int k = 0; k < 400; k++) begin
            cur = rnd();
            cur_tag = 16'($urandom());
            io.in_valid = ($urandom_range(0, 3) != 0);
            io.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        repeat (12) cyc();
        check("rand_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule

// File: doc/ray_aabb_slab_test.md
# ray_aabb_slab_test

Pipelined ray / axis-aligned-bounding-box slab intersection unit that consumes the per-axis inverse ray direction produced by the `ray_inverse_div_wrapper` divider stage, one instance per axis, and decides hit/miss plus entry/exit distances. It sits directly downstream of the inverse-direction dividers and upstream of BVH traversal. It accepts one ray/box pair per cycle under valid/ready flow control, with a fixed pipeline latency.

## Interface
- TAG_W, 16, width of opaque ray tag carried alongside each request
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request this cycle
- in_tag  in  TAG_W  ray identifier, passed through unchanged
- origin_x/y/z  in  28 each  ray origin, signed Q12.16
- inv_dir_x/y/z  in  36 each  inverse direction from divider, signed Q20.16
- dz_x/y/z  in  1 each  divider div_by_zero flag per axis (ray parallel to that slab)
- box_min_x/y/z, box_max_x/y/z  in  28 each  box bounds, signed Q12.16, min <= max per axis
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_tag  out  TAG_W  tag of the result
- hit  out  1  ray intersects box at t >= 0
- t_near, t_far  out  36 each  entry/exit distance, signed Q20.16, saturated

## Operation
- Stall enable: en = !out_valid || out_ready; in_ready = en. When en=0 every pipeline register, including valid bits, holds.
- Transfer occurs on in_valid && in_ready; result retires on out_valid && out_ready.
- S1: register inputs; per axis d_lo = box_min - origin, d_hi = box_max - origin (29-bit signed, no overflow possible).
- S2: per axis p_lo = d_lo * inv_dir, p_hi = d_hi * inv_dir (65-bit signed, Q.32).
- S3: arithmetic shift right 16 -> Q.16; saturate to 36 bits: values > 2^35-1 -> 0x7_FFFF_FFFF, < -2^35 -> 0x8_0000_0000. Per axis a_near = min(t_lo, t_hi), a_far = max(t_lo, t_hi).
- Parallel axis (dz=1): inv_dir ignored; if box_min <= origin <= box_max, a_near = MIN36 (0x8_0000_0000), a_far = MAX36; otherwise the axis forces miss (sticky miss bit).
- S4: t_near = max(a_near over 3 axes), t_far = min(a_far over 3 axes).
- S5 (output register): hit = !miss && (t_near <= t_far) && (t_far >= 0). t_near/t_far are output even on miss (unclamped; t_near is not clamped to 0).
- All comparisons signed. Tag and valid travel in lockstep with data; order strictly preserved.

## Timing
- Latency: 5 cycles from accepting edge to out_valid, absent stalls; each stall cycle adds exactly one.
- Throughput: one request per cycle when out_ready held high.
- in_ready is combinational from out_ready and out_valid; no other combinational input-to-output path.
- Reset: all valid bits 0, out_valid=0, hit=0, t_near=t_far=0, out_tag=0, in_ready=1 the cycle after reset. Reset mid-operation flushes all in-flight requests; none emerge afterwards.
- out_valid && !out_ready: out_tag, hit, t_near, t_far held stable until accepted.
- Simultaneous accept and retire in the same cycle is legal and does not bubble.

## Test plan
- origin (0,0,0), inv_dir all 0x10000, box [0x10000, 0x20000]^3 -> after 5 cycles hit=1, t_near=0x10000, t_far=0x20000.
- X inv_dir = -1.0 (0xF_FFFF_0000), origin 0, box x [-2.0,-1.0], y/z as previous scenario -> x axis near 1.0/far 2.0 after swap; hit=1, t_near=0x10000, t_far=0x20000.
- dz_x=1, origin x=5.0, box x [1.0,2.0] -> hit=0. Same with origin x=1.5 (other axes as first scenario) -> hit=1, t_near=0x10000.
- Box behind ray: inv_dir +1.0, box [-2.0,-1.0]^3 -> t_far=0xF_FFFF_0000 (-1.0), hit=0. inv_dir 0x7_FFFF_FFFF with d=100.0 -> t_near/t_far saturate to 0x7_FFFF_FFFF.
- 8 back-to-back requests, tags 0..7, out_ready low for 3 cycles mid-stream -> all 8 emerge in order, none lost or duplicated, outputs stable while stalled.
- Assert rst with 3 requests in flight -> out_valid=0 next cycle; no stale results appear after reset is released.
